// File: rtl/fetch_queue.sv
// fetch_queue
// -----------
// Decoupling FIFO between fetch and decode. Each entry carries one fetched
// instruction plus its branch-prediction metadata (pc, pc+4, predicted
// target, BTB way, predicted-taken). Entries leave in program order.
// A branch-misprediction flush drops every entry on the next edge.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN):
//   When defined, an empty queue forwards a pushed entry straight to the
//   head outputs in the same cycle. If decode pops it in that cycle, the
//   entry is consumed and never stored.
//
// Ports:
//   i_clk                  clock, rising edge
//   i_arst                 asynchronous active-low reset
//   i_push                 fetch offers an instruction this cycle
//   i_instruction          fetched instruction
//   i_pc / i_pc_plus4      pc and pc+4 of the instruction
//   i_pc_target_addr_pred  predicted branch target
//   i_btb_way              BTB way of the prediction
//   i_branch_taken_pred    predicted taken
//   i_pop                  decode consumes the head entry this cycle
//   i_flush                branch misprediction, discard all entries
//   o_full                 queue holds DEPTH entries (registered only)
//   o_valid                head entry available
//   o_instruction ..       head entry fields, 0 when o_valid is 0
//   o_branch_taken_pred
//   o_count                occupancy
//
// Handshake: a push transfers when i_push && !o_full && !i_flush; a pop
// transfers when i_pop && o_valid && !i_flush. A push offered while o_full
// is dropped, so fetch must hold its pc until o_full falls. i_flush
// overrides both sides in the same cycle.

module fetch_queue #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                     i_clk,
    input  logic                     i_arst,
    input  logic                     i_push,
    input  logic [INSTR_WIDTH-1:0]   i_instruction,
    input  logic [ADDR_WIDTH-1:0]    i_pc,
    input  logic [ADDR_WIDTH-1:0]    i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0]    i_pc_target_addr_pred,
    input  logic [1:0]               i_btb_way,
    input  logic                     i_branch_taken_pred,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_full,
    output logic                     o_valid,
    output logic [INSTR_WIDTH-1:0]   o_instruction,
    output logic [ADDR_WIDTH-1:0]    o_pc,
    output logic [ADDR_WIDTH-1:0]    o_pc_plus4,
    output logic [ADDR_WIDTH-1:0]    o_pc_target_addr_pred,
    output logic [1:0]               o_btb_way,
    output logic                     o_branch_taken_pred,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instruction;
        logic [ADDR_WIDTH-1:0]  pc;
        logic [ADDR_WIDTH-1:0]  pc_plus4;
        logic [ADDR_WIDTH-1:0]  target;
        logic [1:0]             btb_way;
        logic                   taken;
    } entry_t;

    entry_t               mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    entry_t               in_entry;
    entry_t               head_entry;
    logic                 empty;
    logic                 full;
    logic                 bypass_hit;
    logic                 push_acc;
    logic                 pop_acc;

    assign in_entry = '{instruction: i_instruction,
                        pc:          i_pc,
                        pc_plus4:    i_pc_plus4,
                        target:      i_pc_target_addr_pred,
                        btb_way:     i_btb_way,
                        taken:       i_branch_taken_pred};

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue with an incoming push presents that push at the head.
    // i_arst gates o_valid so outputs stay 0 while reset is held even if
    // fetch keeps pushing.
    assign bypass_hit = empty && i_push && !i_flush;
    assign o_valid    = (!empty || i_push) && !i_flush && i_arst;
    // Bypassed entry popped in the same cycle is never written.
    assign push_acc   = i_push && !full && !i_flush && !(bypass_hit && i_pop);
    assign head_entry = bypass_hit ? in_entry : mem_q[rd_ptr_q];
`else
    assign bypass_hit = 1'b0;
    assign o_valid    = !empty && !i_flush;
    assign push_acc   = i_push && !full && !i_flush;
    assign head_entry = mem_q[rd_ptr_q];
`endif

    // In bypass mode a pop of the forwarded entry leaves rd_ptr and count
    // alone, since that entry never entered storage.
    assign pop_acc = i_pop && o_valid && !i_flush && !bypass_hit;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; head outputs are masked by o_valid instead.
    always_ff @(posedge i_clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign o_full                = full;
    assign o_count               = count_q;
    assign o_instruction         = o_valid ? head_entry.instruction : '0;
    assign o_pc                  = o_valid ? head_entry.pc          : '0;
    assign o_pc_plus4            = o_valid ? head_entry.pc_plus4    : '0;
    assign o_pc_target_addr_pred = o_valid ? head_entry.target      : '0;
    assign o_btb_way             = o_valid ? head_entry.btb_way     : '0;
    assign o_branch_taken_pred   = o_valid ? head_entry.taken       : 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, 64-bit addresses). Inputs are
// driven 1ns after the rising edge and outputs are sampled before the next
// edge. Expected head pcs are kept in exp_q; the other head fields are
// derived from the pc so every popped field can be checked.

module tb_fetch_queue;

    localparam int AW = 64;
    localparam int IW = 32;
    localparam int D  = 4;

    logic          clk;
    logic          arst;
    logic          push;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
    logic [AW-1:0] tgt;
    logic [1:0]    way;
    logic          taken;
    logic          pop;
    logic          flush;
    logic          full;
    logic          valid;
    logic [IW-1:0] o_instr;
    logic [AW-1:0] o_pc;
    logic [AW-1:0] o_pc4;
    logic [AW-1:0] o_tgt;
    logic [1:0]    o_way;
    logic          o_taken;
    logic [2:0]    count;

    logic [AW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;

    fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(D)) dut (
        .i_clk                 (clk),
        .i_arst                (arst),
        .i_push                (push),
        .i_instruction         (instr),
        .i_pc                  (pc),
        .i_pc_plus4            (pc4),
        .i_pc_target_addr_pred (tgt),
        .i_btb_way             (way),
        .i_branch_taken_pred   (taken),
        .i_pop                 (pop),
        .i_flush               (flush),
        .o_full                (full),
        .o_valid               (valid),
        .o_instruction         (o_instr),
        .o_pc                  (o_pc),
        .o_pc_plus4            (o_pc4),
        .o_pc_target_addr_pred (o_tgt),
        .o_btb_way             (o_way),
        .o_branch_taken_pred   (o_taken),
        .o_count               (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Field derivation used for every generic entry.
    function automatic logic [IW-1:0] f_instr(input logic [AW-1:0] p);
        return p[IW-1:0] ^ 32'hABCD_0000;
    endfunction
    function automatic logic [AW-1:0] f_tgt(input logic [AW-1:0] p);
        return p + 64'h100;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic ps, input logic [AW-1:0] p, input logic pp, input logic fl);
        push  = ps;
        pc    = p;
        pc4   = p + 64'd4;
        tgt   = f_tgt(p);
        instr = f_instr(p);
        way   = p[3:2];
        taken = p[2];
        pop   = pp;
        flush = fl;
    endtask

    task automatic idle();
        set_inputs(1'b0, '0, 1'b0, 1'b0);
    endtask

    // One cycle of traffic: checks the head against the scoreboard when a
    // pop is due, updates the model, then clocks and checks occupancy.
    task automatic drive_cycle(input logic ps, input logic [AW-1:0] p, input logic pp, input logic fl);
        int  sz;
        logic [AW-1:0] h;
        set_inputs(ps, p, pp, fl);
        #1;
        sz = exp_q.size();
        if (fl) begin
            check("flush_valid", {63'd0, valid}, 64'd0);
            exp_q.delete();
        end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
            if (sz == 0 && ps) begin
                check("byp_valid", {63'd0, valid}, 64'd1);
                check("byp_pc", o_pc, p);
                if (!pp) exp_q.push_back(p);
            end else
`endif
            begin
                if (pp && sz != 0) begin
                    h = exp_q.pop_front();
                    check("head_valid", {63'd0, valid}, 64'd1);
                    check("head_pc", o_pc, h);
                    check("head_pc4", o_pc4, h + 64'd4);
                    check("head_tgt", o_tgt, f_tgt(h));
                    check("head_instr", {32'd0, o_instr}, {32'd0, f_instr(h)});
                    check("head_way", {62'd0, o_way}, {62'd0, h[3:2]});
                    check("head_taken", {63'd0, o_taken}, {63'd0, h[2]});
                end
                if (ps && sz < D) exp_q.push_back(p);
            end
        end
        step();
        check("count", {61'd0, count}, 64'(exp_q.size()));
        check("full", {63'd0, full}, {63'd0, exp_q.size() == D});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        arst = 1'b1;
        idle();
        #2 arst = 1'b0;
        #1;
        // reset then idle
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_pc", o_pc, 64'd0);
        step();
        arst = 1'b1;
        step();

        // fill to full, overflow push dropped, drain in order
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 64'h1000 + 64'(4 * k), 1'b0, 1'b0);
        check("fill_count", {61'd0, count}, 64'd4);
        check("fill_full", {63'd0, full}, 64'd1);
        drive_cycle(1'b1, 64'h1010, 1'b0, 1'b0);
        check("ovf_count", {61'd0, count}, 64'd4);
        for (int k = 0; k < 4; k++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        idle();
        #1;
        check("drain_valid", {63'd0, valid}, 64'd0);
        check("drain_pc", o_pc, 64'd0);

        // wrap-around: two entries resident, then 10 cycles push+pop
        drive_cycle(1'b1, 64'h2000, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'h2004, 1'b0, 1'b0);
        for (int k = 2; k < 12; k++) begin
            drive_cycle(1'b1, 64'h2000 + 64'(4 * k), 1'b1, 1'b0);
            check("wrap_count", {61'd0, count}, 64'd2);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        check("wrap_empty", {61'd0, count}, 64'd0);

        // flush with 3 entries and simultaneous push+pop
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, 64'h2800 + 64'(4 * k), 1'b0, 1'b0);
        drive_cycle(1'b1, 64'h3000, 1'b1, 1'b1);
        idle();
        #1;
        check("flush_count", {61'd0, count}, 64'd0);
        check("flush_valid_after", {63'd0, valid}, 64'd0);
        drive_cycle(1'b1, 64'h4000, 1'b0, 1'b0);
        idle();
        #1;
        check("post_flush_pc", o_pc, 64'h4000);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);

        // metadata integrity with explicit field values
        push = 1'b1; pc = 64'h4800; pc4 = 64'h4804; tgt = 64'h5000;
        instr = 32'h0000_0063; way = 2'd2; taken = 1'b1; pop = 1'b0; flush = 1'b0;
        step();
        idle();
        #1;
        check("meta_instr", {32'd0, o_instr}, 64'h63);
        check("meta_pc", o_pc, 64'h4800);
        check("meta_pc4", o_pc4, 64'h4804);
        check("meta_tgt", o_tgt, 64'h5000);
        check("meta_way", {62'd0, o_way}, 64'd2);
        check("meta_taken", {63'd0, o_taken}, 64'd1);
        pop = 1'b1;
        step();
        idle();
        #1;
        check("meta_popped", {61'd0, count}, 64'd0);

        // empty queue, push and pop together
        drive_cycle(1'b1, 64'h6000, 1'b1, 1'b0);
        idle();
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check("emp_pp_count", {61'd0, count}, 64'd0);
        check("emp_pp_valid", {63'd0, valid}, 64'd0);
`else
        check("emp_pp_count", {61'd0, count}, 64'd1);
        check("emp_pp_head", o_pc, 64'h6000);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
`endif

        // asynchronous reset with 3 entries held, mid-cycle
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, 64'h7000 + 64'(4 * k), 1'b0, 1'b0);
        idle();
        #1;
        check("pre_rst_count", {61'd0, count}, 64'd3);
        arst = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, valid}, 64'd0);
        check("async_rst_count", {61'd0, count}, 64'd0);
        check("async_rst_pc", o_pc, 64'd0);
        exp_q.delete();
        step();
        arst = 1'b1;
        step();
        check("post_rst_count", {61'd0, count}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the fetch stage and the decode stage.
- Captures each fetched instruction together with its branch-prediction metadata: pc, pc+4, predicted target, BTB way, predicted-taken.
- Presents entries to decode in program order.
- Absorbs decode stalls, back-pressures fetch through o_full, and drops all contents on a branch misprediction flush.

Parameters:
- ADDR_WIDTH, 64, width of all address fields.
- INSTR_WIDTH, 32, instruction width.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_arst  in  1  reset; asynchronous and active-low (0 = reset).
- i_push  in  1  fetch has a valid instruction this cycle (icache hit and fetch not stalled).
- i_instruction  in  INSTR_WIDTH  fetched instruction.
- i_pc  in  ADDR_WIDTH  pc of the instruction.
- i_pc_plus4  in  ADDR_WIDTH  pc + 4.
- i_pc_target_addr_pred  in  ADDR_WIDTH  predicted target.
- i_btb_way  in  2  BTB way.
- i_branch_taken_pred  in  1  predicted taken.
- i_pop  in  1  decode consumes the head entry this cycle.
- i_flush  in  1  branch misprediction; discard all entries.
- o_full  out  1  count == DEPTH; fetch stalls on this.
- o_valid  out  1  head entry available.
- o_instruction, o_pc, o_pc_plus4, o_pc_target_addr_pred, o_btb_way, o_branch_taken_pred  out  same widths as inputs  head entry fields.
- o_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (i_arst=0, asynchronous): wr_ptr, rd_ptr and count cleared immediately. All outputs read 0 while reset is held, including mid-operation. Storage array is not reset.
- Push accepted when i_push=1, o_full=0 and i_flush=0. Entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Push while full is ignored and the entry is lost. Fetch must hold its pc while o_full=1.
- Pop accepted when i_pop=1, o_valid=1 and i_flush=0. rd_ptr increments modulo DEPTH. Pop while empty is ignored.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
  - Never exceeds DEPTH and never underflows.
- o_full depends only on registered count; it has no combinational path from i_pop.
- Flush has highest priority. Next edge: count = 0 and wr_ptr = rd_ptr = 0. Same-cycle push and pop are discarded.
- o_valid = (count != 0) and not i_flush.
- Data outputs equal mem[rd_ptr] when o_valid=1, otherwise forced to 0.
- Latency: an entry pushed at edge N is visible on the head outputs in cycle N+1 and leaves the head on the edge where it is popped.
- Order: strict FIFO. Pointer wrap from DEPTH-1 to 0 is transparent to ordering.
- Empty with push and pop in the same cycle: push accepted, pop ignored (o_valid was 0), count becomes 1.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- When defined, the empty queue becomes zero-latency:
  - When count == 0 and i_push=1 and i_flush=0, o_valid=1 combinationally and the head outputs show the input fields.
  - If i_pop=1 in that cycle, the entry is consumed and never written; count stays 0.
  - Otherwise the entry is written as normal.
  - In this mode, o_valid = ((count != 0) or i_push) and not i_flush.
- When undefined, behaviour is exactly as in Behaviour above: minimum one-cycle latency and no combinational path from push inputs to outputs.

Test Plan:
- Reset then idle: outputs all 0, o_count=0. Assert i_arst=0 with 3 entries held -> o_valid=0 and o_count=0 immediately, without waiting for a clock edge.
- Push pc 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles with i_pop=0:
  - o_count reaches 4 and o_full=1.
  - A 5th push with pc 0x1010 is ignored.
  - Popping 4 times yields 0x1000..0x100C in order, then o_valid=0.
- Wrap-around: continuous push and pop for 10 cycles with pcs 0x2000 + 4k -> o_count stays constant, output order is preserved across the pointer wrap, and no entry is lost.
- Flush with count=3 and simultaneous push of pc 0x3000 and i_pop=1 -> next cycle o_count=0 and o_valid=0; pc 0x3000 never appears. A push of 0x4000 on the following cycle appears at the head one cycle later.
- Metadata integrity: push instruction 0x00000063, btb_way=2, taken_pred=1, target 0x5000 -> popped head shows identical fields.
- Empty with push and pop in the same cycle:
  - Without FETCH_QUEUE_BYPASS_EN: count becomes 1, and the head appears next cycle.
  - With FETCH_QUEUE_BYPASS_EN: o_valid=1 in the same cycle with the input pc, and o_count stays 0.
